// File: rtl/uart_defs_pkg.sv
// Shared UART definitions: receiver FSM encoding and bit-timing helpers,
// used by both the receive and transmit paths.
package uart_defs;

    // Receiver FSM states.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } rx_state_e;

    // Clock cycles per bit period (integer division).
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    // Clock cycles to the middle of a bit period.
    function automatic int half_bit(input int clk_freq, input int baud);
        return (clk_freq / baud) / 2;
    endfunction

    // Width of a counter that must hold values up to n-1 (at least 1 bit).
    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Single-bit two-flop synchronizer with a configurable reset value.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops give the first stage a full cycle to settle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, valid/ready byte output,
// frame-error and overrun pulses, break (held-low line) suppression.
module uart_rx
    import uart_defs::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int HALF_BIT     = half_bit(CLK_FREQ, BAUD);
    localparam int CNT_W        = cnt_width(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

    logic rx_s;

    rx_state_e        state_q,     state_d;
    logic [CNT_W-1:0] clk_cnt_q,   clk_cnt_d;
    logic [2:0]       bit_cnt_q,   bit_cnt_d;
    logic [7:0]       shift_q,     shift_d;
    logic [7:0]       data_q,      data_d;
    logic             valid_q,     valid_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q,   overrun_d;

    logic deliver;
    logic stop_bad;

    // Idle-high reset value keeps reset from looking like a start bit.
    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx),
        .q_o (rx_s)
    );

    // State, counters, shift register and output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            clk_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    // Next-state logic: frame sequencing plus byte delivery to the consumer.
    always_comb begin
        state_d     = state_q;
        clk_cnt_d   = clk_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        deliver     = 1'b0;
        stop_bad    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                clk_cnt_d = '0;
                if (!rx_s) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (clk_cnt_q == HALF_LAST) begin
                    clk_cnt_d = '0;
                    if (!rx_s) begin
                        state_d   = S_DATA;
                        bit_cnt_d = '0;
                    end else begin
                        // Start bit vanished by mid-bit: treat as a glitch.
                        state_d = S_IDLE;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    if (rx_s) begin
                        deliver = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        stop_bad = 1'b1;
                        state_d  = S_BREAK;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            S_BREAK: begin
                // Hold off until the line returns high so a stuck-low line
                // does not produce a stream of bogus frames.
                clk_cnt_d = '0;
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d   = S_IDLE;
                clk_cnt_d = '0;
            end
        endcase

        frame_err_d = stop_bad;

        if (deliver) begin
            if (!valid_q || ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                // Unconsumed byte wins; the new one is dropped.
                overrun_d = 1'b1;
            end
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at default 50 MHz / 115200 baud.
module tb_uart_rx;

    localparam int CLK_FREQ = 50000000;
    localparam int BAUD     = 115200;
    localparam int CPB      = CLK_FREQ / BAUD;   // 434
    localparam int HALF     = CPB / 2;           // 217
    // Cycles from driving the start edge to valid being visible:
    // 2 sync flops + 1 cycle for IDLE to see it, then HALF to the start
    // sample, then 9 bit periods to the stop sample (valid set on that edge).
    localparam int RISE_CYC = 3 + HALF + 9 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;

    uart_rx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #10 clk = ~clk;

    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;
    int   fe_seen = 0;
    int   ov_seen = 0;
    int   vrise_cnt = 0;
    int   vrise_cyc = -1;
    int   ready_at = -1;
    int   frame_start = 0;
    logic prev_valid = 1'b0;

    typedef struct {
        logic [7:0] byte_v;
        logic       stop_v;
        logic [7:0] exp_data;
        logic       exp_valid;
        int         exp_fe;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock of stimulus: sample outputs at the falling edge, then drive.
    task automatic step(input logic lvl);
        @(negedge clk);
        if (frame_err) fe_seen++;
        if (overrun) ov_seen++;
        if (valid && !prev_valid) begin
            vrise_cnt++;
            vrise_cyc = cyc;
        end
        prev_valid = valid;
        ready = (cyc == ready_at);
        rx = lvl;
        cyc++;
    endtask

    task automatic clear_counts();
        fe_seen   = 0;
        ov_seen   = 0;
        vrise_cnt = 0;
        vrise_cyc = -1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_b);
        frame_start = cyc;
        repeat (CPB) step(1'b0);
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) step(b[i]);
        end
        repeat (CPB) step(stop_b);
    endtask

    // Pulse ready for one cycle; returns with valid showing the result.
    task automatic consume();
        ready_at = cyc;
        step(1'b1);
        step(1'b1);
    endtask

    initial begin
        vecs[0] = '{8'hFF, 1'b1, 8'hFF, 1'b1, 0};
        vecs[1] = '{8'h3C, 1'b0, 8'hFF, 1'b0, 1};
        vecs[2] = '{8'h81, 1'b1, 8'h81, 1'b1, 0};
        vecs[3] = '{8'h00, 1'b1, 8'h00, 1'b1, 0};

        // Reset and idle line.
        repeat (3) step(1'b1);
        chk("rst_data", int'(data), 8'h00);
        chk("rst_valid", int'(valid), 0);
        rst = 1'b0;
        clear_counts();
        repeat (10 * CPB) step(1'b1);
        chk("idle_valid_rises", vrise_cnt, 0);
        chk("idle_frame_err", fe_seen, 0);
        chk("idle_overrun", ov_seen, 0);
        chk("idle_data", int'(data), 8'h00);

        // Single byte A5 with ready low: exact valid timing, then handshake.
        clear_counts();
        send_frame(8'hA5, 1'b1);
        chk("a5_data", int'(data), 8'hA5);
        chk("a5_valid", int'(valid), 1);
        chk("a5_rise_cycle", vrise_cyc - frame_start, RISE_CYC);
        chk("a5_errs", fe_seen + ov_seen, 0);
        consume();
        chk("a5_valid_cleared", int'(valid), 0);
        chk("a5_data_kept", int'(data), 8'hA5);

        // Table: good frames and a framing error followed by a held-low line.
        for (int v = 0; v < 4; v++) begin
            if (valid) consume();
            clear_counts();
            send_frame(vecs[v].byte_v, vecs[v].stop_v);
            if (!vecs[v].stop_v) begin
                repeat (20 * CPB) step(1'b0);
                repeat (2 * CPB) step(1'b1);
            end
            chk($sformatf("vec%0d_data", v), int'(data), int'(vecs[v].exp_data));
            chk($sformatf("vec%0d_valid", v), int'(valid), int'(vecs[v].exp_valid));
            chk($sformatf("vec%0d_frame_err", v), fe_seen, vecs[v].exp_fe);
            chk($sformatf("vec%0d_overrun", v), ov_seen, 0);
        end

        // Back-to-back 55, 0F with ready low: second byte overruns.
        if (valid) consume();
        clear_counts();
        send_frame(8'h55, 1'b1);
        send_frame(8'h0F, 1'b1);
        chk("b2b_data", int'(data), 8'h55);
        chk("b2b_valid", int'(valid), 1);
        chk("b2b_overrun", ov_seen, 1);
        chk("b2b_frame_err", fe_seen, 0);
        consume();
        chk("b2b_consumed", int'(valid), 0);

        // Same bytes, ready asserted in the cycle the second byte completes.
        clear_counts();
        send_frame(8'h55, 1'b1);
        ready_at = cyc + RISE_CYC - 1;
        send_frame(8'h0F, 1'b1);
        ready_at = -1;
        chk("hs_data", int'(data), 8'h0F);
        chk("hs_valid", int'(valid), 1);
        chk("hs_overrun", ov_seen, 0);
        chk("hs_valid_rises", vrise_cnt, 1);

        // 100-cycle glitch on idle line (valid still holds 0F).
        clear_counts();
        repeat (100) step(1'b0);
        repeat (12 * CPB) step(1'b1);
        chk("glitch_events", vrise_cnt + fe_seen + ov_seen, 0);
        chk("glitch_data", int'(data), 8'h0F);

        // Reset during data bit 4, then a clean C3 frame.
        repeat (CPB) step(1'b0);
        for (int i = 0; i < 4; i++) begin
            repeat (CPB) step(i[0]);
        end
        repeat (HALF) step(1'b1);
        rst = 1'b1;
        repeat (3) step(1'b1);
        chk("midrst_data", int'(data), 8'h00);
        chk("midrst_valid", int'(valid), 0);
        chk("midrst_pulses", int'(frame_err) + int'(overrun), 0);
        rst = 1'b0;
        clear_counts();
        repeat (2 * CPB) step(1'b1);
        send_frame(8'hC3, 1'b1);
        chk("c3_data", int'(data), 8'hC3);
        chk("c3_valid", int'(valid), 1);
        chk("c3_errs", fe_seen + ov_seen, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
